// File: rtl/control_unit.sv
// control_unit: Moore sequencer that drives every control input of the Mini SRC datapath.
// Latency: 4..8 cycles per instruction, plus 1 per memory wait cycle (F1, ld-T6, st-T7).
// Backpressure: holds in a wait state while mem_rdy=0; clr resets asynchronously; HALT is left only via clr.
//
// Ports:
//   clk, clr            clock, asynchronous active-high reset
//   ir, con_ff, mem_rdy IR contents (opcode in ir[31:27]), branch condition, memory handshake
//   *out                bus-source selects
//   *In, IncPC          register load enables
//   Gra/Grb/Grc/Rin/Rout/BAout  register-select/encode strobes
//   read, write         memory strobes
//   alu_op              ALU operation code
//   run                 high while executing (not in RESET or HALT)
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_rdy,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        Cout,
  output logic        In_Portout,
  output logic        LOout,
  output logic        HIout,
  output logic        MARIn,
  output logic        ZIn,
  output logic        PCIn,
  output logic        MDRIn,
  output logic        IRIn,
  output logic        YIn,
  output logic        IncPC,
  output logic        HiIn,
  output logic        LoIn,
  output logic        CONin,
  output logic        OutPortIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        read,
  output logic        write,
  output logic [4:0]  alu_op,
  output logic        run
);

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_F0    = 4'd1;
  localparam logic [3:0] S_F1    = 4'd2;
  localparam logic [3:0] S_F2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_T7    = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;

  localparam logic [4:0] OP_ADD = 5'b00011;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [4:0] w_opc;
  logic       w_unused_ir;

  // Opcode classes
  logic w_alu, w_imm, w_muldiv, w_negnot;
  logic w_ld, w_ldi, w_st, w_br, w_jr, w_in, w_out, w_mfhi, w_mflo, w_halt;
  logic w_multi;

  assign w_opc       = ir[31:27];
  assign w_unused_ir = ^ir[26:0];

  assign w_ld     = (w_opc == 5'd0);
  assign w_ldi    = (w_opc == 5'd1);
  assign w_st     = (w_opc == 5'd2);
  assign w_alu    = (w_opc >= 5'd3)  && (w_opc <= 5'd10);
  assign w_imm    = (w_opc >= 5'd11) && (w_opc <= 5'd13);
  assign w_muldiv = (w_opc == 5'd14) || (w_opc == 5'd15);
  assign w_negnot = (w_opc == 5'd16) || (w_opc == 5'd17);
  assign w_br     = (w_opc == 5'd18);
  assign w_jr     = (w_opc == 5'd19);
  assign w_in     = (w_opc == 5'd21);
  assign w_out    = (w_opc == 5'd22);
  assign w_mfhi   = (w_opc == 5'd23);
  assign w_mflo   = (w_opc == 5'd24);
  assign w_halt   = (w_opc == 5'd26);

  // Opcodes whose execute sequence runs past T3; everything else finishes in T3.
  assign w_multi = w_alu | w_imm | w_muldiv | w_negnot | w_ld | w_ldi | w_st | w_br;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= S_RESET;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET: w_next = S_F0;
      S_F0:    w_next = S_F1;
      S_F1:    if (mem_rdy) w_next = S_F2;
      S_F2:    w_next = S_T3;
      S_T3: begin
        if (w_halt)       w_next = S_HALT;
        else if (w_multi) w_next = S_T4;
        else              w_next = S_F0;
      end
      S_T4:    w_next = w_negnot ? S_F0 : S_T5;
      S_T5:    w_next = (w_alu | w_imm | w_ldi) ? S_F0 : S_T6;
      S_T6: begin
        if (w_ld) begin
          if (mem_rdy) w_next = S_T7;
        end else if (w_st) begin
          w_next = S_T7;
        end else begin
          w_next = S_F0;
        end
      end
      // Only ld and st reach T7; st holds here until the write completes.
      S_T7:    if (w_ld || mem_rdy) w_next = S_F0;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_RESET;
    endcase
  end

  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
    Cout = 1'b0; In_Portout = 1'b0; LOout = 1'b0; HIout = 1'b0;
    MARIn = 1'b0; ZIn = 1'b0; PCIn = 1'b0; MDRIn = 1'b0; IRIn = 1'b0;
    YIn = 1'b0; IncPC = 1'b0; HiIn = 1'b0; LoIn = 1'b0; CONin = 1'b0;
    OutPortIn = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    read = 1'b0; write = 1'b0;
    alu_op = 5'd0;
    run = (r_state != S_RESET) && (r_state != S_HALT);
    case (r_state)
      S_F0: begin PCout = 1'b1; MARIn = 1'b1; IncPC = 1'b1; ZIn = 1'b1; end
      S_F1: begin Zlowout = 1'b1; PCIn = 1'b1; read = 1'b1; MDRIn = 1'b1; end
      S_F2: begin MDRout = 1'b1; IRIn = 1'b1; end
      S_T3: begin
        if (w_alu | w_imm) begin
          Grb = 1'b1; Rout = 1'b1; YIn = 1'b1;
        end else if (w_muldiv) begin
          Gra = 1'b1; Rout = 1'b1; YIn = 1'b1;
        end else if (w_negnot) begin
          Grb = 1'b1; Rout = 1'b1; ZIn = 1'b1; alu_op = w_opc;
        end else if (w_ld | w_ldi | w_st) begin
          Grb = 1'b1; BAout = 1'b1; YIn = 1'b1;
        end else if (w_br) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end else if (w_jr) begin
          Gra = 1'b1; Rout = 1'b1; PCIn = 1'b1;
        end else if (w_in) begin
          In_Portout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_out) begin
          Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1;
        end else if (w_mfhi) begin
          HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_mflo) begin
          LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      S_T4: begin
        if (w_alu) begin
          Grc = 1'b1; Rout = 1'b1; ZIn = 1'b1; alu_op = w_opc;
        end else if (w_imm) begin
          Cout = 1'b1; ZIn = 1'b1; alu_op = w_opc;
        end else if (w_muldiv) begin
          Grb = 1'b1; Rout = 1'b1; ZIn = 1'b1; alu_op = w_opc;
        end else if (w_negnot) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_ld | w_ldi | w_st) begin
          // Effective address = base + offset, computed with the ALU's add.
          Cout = 1'b1; ZIn = 1'b1; alu_op = OP_ADD;
        end else if (w_br) begin
          PCout = 1'b1; YIn = 1'b1;
        end
      end
      S_T5: begin
        if (w_alu | w_imm | w_ldi) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_muldiv) begin
          Zlowout = 1'b1; LoIn = 1'b1;
        end else if (w_ld | w_st) begin
          Zlowout = 1'b1; MARIn = 1'b1;
        end else if (w_br) begin
          Cout = 1'b1; ZIn = 1'b1; alu_op = OP_ADD;
        end
      end
      S_T6: begin
        if (w_muldiv) begin
          Zhighout = 1'b1; HiIn = 1'b1;
        end else if (w_ld) begin
          read = 1'b1; MDRIn = 1'b1;
        end else if (w_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRIn = 1'b1;
        end else if (w_br) begin
          // Branch target is always on the bus; PC only takes it when taken.
          Zlowout = 1'b1; PCIn = con_ff;
        end
      end
      S_T7: begin
        if (w_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_st) begin
          write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit; driver queues one expected output vector per cycle.
// Latency: monitor checks each vector on the falling edge of the cycle it was queued for.
// Backpressure: mem_rdy is driven low by the driver to exercise each wait state.
module tb_control_unit;

  logic        clk, clr, con_ff, mem_rdy;
  logic [31:0] ir;
  logic PCout, Zlowout, Zhighout, MDRout, Cout, In_Portout, LOout, HIout;
  logic MARIn, ZIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CONin, OutPortIn;
  logic Gra, Grb, Grc, Rin, Rout, BAout, read, write, run;
  logic [4:0] alu_op;

  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .mem_rdy(mem_rdy),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .Cout(Cout), .In_Portout(In_Portout), .LOout(LOout), .HIout(HIout),
    .MARIn(MARIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn), .IRIn(IRIn),
    .YIn(YIn), .IncPC(IncPC), .HiIn(HiIn), .LoIn(LoIn), .CONin(CONin),
    .OutPortIn(OutPortIn), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .read(read), .write(write), .alu_op(alu_op),
    .run(run)
  );

  // Bit masks of the observed output vector.
  localparam logic [32:0] WR  = 33'd1 << 5,  RD  = 33'd1 << 6,  BAO = 33'd1 << 7;
  localparam logic [32:0] RO  = 33'd1 << 8,  RI  = 33'd1 << 9,  GC  = 33'd1 << 10;
  localparam logic [32:0] GB  = 33'd1 << 11, GA  = 33'd1 << 12, OPI = 33'd1 << 13;
  localparam logic [32:0] CNI = 33'd1 << 14, LOI = 33'd1 << 15, HII = 33'd1 << 16;
  localparam logic [32:0] INC = 33'd1 << 17, YI  = 33'd1 << 18, IRI = 33'd1 << 19;
  localparam logic [32:0] MDI = 33'd1 << 20, PCI = 33'd1 << 21, ZI  = 33'd1 << 22;
  localparam logic [32:0] MAI = 33'd1 << 23, HIO = 33'd1 << 24, LOO = 33'd1 << 25;
  localparam logic [32:0] INP = 33'd1 << 26, CO  = 33'd1 << 27, MDO = 33'd1 << 28;
  localparam logic [32:0] ZHO = 33'd1 << 29, ZLO = 33'd1 << 30, PCO = 33'd1 << 31;
  localparam logic [32:0] RUN = 33'd1 << 32;

  localparam logic [32:0] E_F0 = RUN | PCO | MAI | INC | ZI;
  localparam logic [32:0] E_F1 = RUN | ZLO | PCI | RD | MDI;
  localparam logic [32:0] E_F2 = RUN | MDO | IRI;

  logic [32:0] act;
  assign act = {run, PCout, Zlowout, Zhighout, MDRout, Cout, In_Portout, LOout, HIout,
                MARIn, ZIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CONin, OutPortIn,
                Gra, Grb, Grc, Rin, Rout, BAout, read, write, alu_op};

  logic [32:0] exp_q[$];
  string       name_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: pops one expected vector per cycle and compares.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [32:0] e;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s: got %h required %h", nm, act, e);
      end
    end
  end

  // Queue the expected outputs for the current cycle, then move to the next cycle.
  task automatic cyc(input logic [32:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ir_v, input int f1_waits, input string nm);
    ir = ir_v;
    mem_rdy = 1'b1;
    cyc(E_F0, {nm, "_F0"});
    for (int i = 0; i < f1_waits; i++) begin
      mem_rdy = 1'b0;
      cyc(E_F1, {nm, "_F1wait"});
    end
    mem_rdy = 1'b1;
    cyc(E_F1, {nm, "_F1"});
    cyc(E_F2, {nm, "_F2"});
  endtask

  task automatic alu5(input logic [32:0] op);
    return;
  endtask

  initial begin
    clr = 1'b1; ir = 32'h0; con_ff = 1'b0; mem_rdy = 1'b1;
    @(posedge clk);
    #1;
    cyc(33'd0, "reset_a");
    cyc(33'd0, "reset_b");
    clr = 1'b0;
    cyc(33'd0, "reset_release");

    // add r?, r?, r? : 6 cycles
    fetch(32'h1800_0000, 0, "add");
    cyc(RUN | GB | RO | YI, "add_T3");
    cyc(RUN | GC | RO | ZI | 33'd3, "add_T4");
    cyc(RUN | ZLO | GA | RI, "add_T5");

    // clr during T4 of add: outputs drop before the next edge
    fetch(32'h1800_0000, 0, "add2");
    cyc(RUN | GB | RO | YI, "add2_T3");
    clr = 1'b1;
    cyc(33'd0, "clr_mid_T4");
    cyc(33'd0, "clr_hold");
    clr = 1'b0;
    cyc(33'd0, "clr_release");

    // ld with 2 fetch waits and 3 T6 waits
    fetch(32'h0000_0000, 2, "ld");
    cyc(RUN | GB | BAO | YI, "ld_T3");
    cyc(RUN | CO | ZI | 33'd3, "ld_T4");
    cyc(RUN | ZLO | MAI, "ld_T5");
    mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) cyc(RUN | RD | MDI, "ld_T6wait");
    mem_rdy = 1'b1;
    cyc(RUN | RD | MDI, "ld_T6");
    cyc(RUN | MDO | GA | RI, "ld_T7");

    // br not taken, then taken
    for (int t = 0; t < 2; t++) begin
      con_ff = 1'b0;
      fetch(32'h9000_0000, 0, "br");
      cyc(RUN | GA | RO | CNI, "br_T3");
      cyc(RUN | PCO | YI, "br_T4");
      cyc(RUN | CO | ZI | 33'd3, "br_T5");
      con_ff = (t == 1);
      if (t == 0) cyc(RUN | ZLO, "br_T6_nottaken");
      else        cyc(RUN | ZLO | PCI, "br_T6_taken");
    end
    con_ff = 1'b0;

    // mul
    fetch(32'h7000_0000, 0, "mul");
    cyc(RUN | GA | RO | YI, "mul_T3");
    cyc(RUN | GB | RO | ZI | 33'd14, "mul_T4");
    cyc(RUN | ZLO | LOI, "mul_T5");
    cyc(RUN | ZHO | HII, "mul_T6");

    // st with one write wait
    fetch(32'h1000_0000, 0, "st");
    cyc(RUN | GB | BAO | YI, "st_T3");
    cyc(RUN | CO | ZI | 33'd3, "st_T4");
    cyc(RUN | ZLO | MAI, "st_T5");
    mem_rdy = 1'b0;
    cyc(RUN | GA | RO | MDI, "st_T6");
    cyc(RUN | WR, "st_T7wait");
    mem_rdy = 1'b1;
    cyc(RUN | WR, "st_T7");

    // unused opcode 11111 behaves as nop
    fetch(32'hF800_0000, 0, "unused");
    cyc(RUN, "unused_T3");

    // neg, addi, in, mfhi
    fetch(32'h8000_0000, 0, "neg");
    cyc(RUN | GB | RO | ZI | 33'd16, "neg_T3");
    cyc(RUN | ZLO | GA | RI, "neg_T4");
    fetch(32'h5800_0000, 0, "addi");
    cyc(RUN | GB | RO | YI, "addi_T3");
    cyc(RUN | CO | ZI | 33'd11, "addi_T4");
    cyc(RUN | ZLO | GA | RI, "addi_T5");
    fetch(32'hA800_0000, 0, "in");
    cyc(RUN | INP | GA | RI, "in_T3");
    fetch(32'hB800_0000, 0, "mfhi");
    cyc(RUN | HIO | GA | RI, "mfhi_T3");

    // halt: parks for 20 cycles regardless of mem_rdy
    fetch(32'hD000_0000, 0, "halt");
    cyc(RUN, "halt_T3");
    for (int i = 0; i < 20; i++) begin
      mem_rdy = i[0];
      cyc(33'd0, "halt_idle");
    end
    mem_rdy = 1'b1;

    // clr leaves HALT; then clr during an F1 wait
    clr = 1'b1;
    cyc(33'd0, "halt_clr");
    clr = 1'b0;
    cyc(33'd0, "halt_clr_release");
    ir = 32'hC800_0000;
    cyc(E_F0, "post_halt_F0");
    mem_rdy = 1'b0;
    cyc(E_F1, "wait_F1");
    clr = 1'b1;
    cyc(33'd0, "clr_mid_wait");
    clr = 1'b0;
    mem_rdy = 1'b1;
    cyc(33'd0, "wait_clr_release");
    fetch(32'hC800_0000, 0, "nop");
    cyc(RUN, "nop_T3");
    cyc(E_F0, "after_nop_F0");

    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
